side_sensor_req: RTL and testbench
==================================

# side_sensor_req

Request generator for the side-street vehicle sensor. Synchronizes and debounces the raw loop-detector input, then raises a latched request `s` toward the signal controller. The request is held until the controller acknowledges it, after which a hold-off window blocks re-triggering. This block is the driving end of the controller's `s` input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples required before a request is raised. Legal range is 2..255.
- `HOLDOFF_CYCLES`, default 8: cycles after an acknowledge during which the sensor is ignored. Legal range is 1..255.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `sensor_raw` input, 1 bit: raw vehicle sensor, asynchronous to `clk`.
- `ack` input, 1 bit: acknowledge from the signal controller. Sampled only in REQ.
- `s` output, 1 bit: registered vehicle-waiting request to the controller.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `req_count` output, 8 bits: number of acknowledged requests, saturating at 255.

## Operation
- **Synchronizer.** `sensor_raw` passes through two flops, `sync1` then `sens_s`. Only `sens_s` feeds the FSM.
- **FSM states.** IDLE, DEBOUNCE, REQ, HOLDOFF. A counter `cnt` is 8 bits wide.
- **IDLE.**
  - `sens_s`=1: go to DEBOUNCE with `cnt`=1.
  - Otherwise: stay in IDLE.
- **DEBOUNCE.**
  - `sens_s`=0: go to IDLE with `cnt`=0. Any glitch restarts the count.
  - `sens_s`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to REQ and set `s`=1.
  - `sens_s`=1 otherwise: increment `cnt`.
- **REQ.**
  - `s` stays 1 for as long as the state is REQ.
  - The sensor going low does not cancel the request; it is latched.
  - On an edge with `ack`=1: go to HOLDOFF, set `s`=0 and `cnt`=0, and increment `req_count` unless it is already 255.
- **HOLDOFF.**
  - `sensor_raw` is ignored. `ack` is ignored.
  - `cnt` increments each edge. When `cnt`==HOLDOFF_CYCLES-1, go to IDLE.
- **Sustained vehicle.** If the sensor is still high after the hold-off, a full new debounce runs before the next request.
- **`ack` outside REQ.** Ignored in IDLE, DEBOUNCE and HOLDOFF. It has no effect on state or count.
- **Reset.**
  - `rst` high forces immediately: state IDLE, `sync1`=0, `sens_s`=0, `cnt`=0, `s`=0, `busy`=0, `req_count`=0.
  - Reset mid-REQ drops `s` asynchronously. No count is recorded.
  - After `rst` is released, a request requires a fresh debounce.

## Timing
- **Request latency.** Let the edge that first captures `sensor_raw`=1 into `sync1` be edge k. With the sensor held high, `s` rises after edge k+DEBOUNCE_CYCLES+1. With the default, that is edge k+5.
- **Minimum pulse.** A raw pulse shorter than DEBOUNCE_CYCLES cycles never produces `s`.
- **Acknowledge.** `s` falls, and `req_count` updates, after the first edge at which `ack`=1 while in REQ.
  - There is no timeout; REQ waits indefinitely.
  - `ack` may already be high on the first REQ cycle. It is then taken on the next edge, so `s` is high for exactly 1 cycle.
- **Hold-off duration.** From the acknowledge edge, the FSM returns to IDLE after exactly HOLDOFF_CYCLES edges.
- **Earliest re-request.** The next `s` rise can come no sooner than HOLDOFF_CYCLES+DEBOUNCE_CYCLES+1 edges after the acknowledge edge, assuming `sens_s` is continuously high.
- **`busy`** is combinational from the state register: high during DEBOUNCE, REQ and HOLDOFF.
- **All outputs** are glitch-free: registered, or decoded from registered state only.

## Test plan
1. **Basic request.** Reset, then raise `sensor_raw` and hold it high; `ack` is 0. Required: `s` rises 5 edges after the first capture edge, `busy`=1 from the edge after `sens_s` goes high, and `req_count`=0.
2. **Glitch rejection.** Apply 3-cycle `sensor_raw` pulses separated by 2 low cycles, repeated 10 times. Required: `s` stays 0 throughout, and `busy` returns to 0 after each pulse.
3. **Acknowledge and hold-off.** Keep the sensor high through the request, then pulse `ack` for 1 cycle. Required: `s`=0 on the next edge, `req_count`=1, and a new `s` rise exactly 8+4+1=13 edges after the acknowledge edge.
4. **Latched request.** Drop `sensor_raw` 2 cycles after `s` rises, then hold `ack`=0 for 50 cycles. Required: `s` stays 1 until `ack`. Also pulse `ack` while in IDLE or HOLDOFF: no state or count change.
5. **Counter saturation.** Run 260 request/acknowledge cycles. Required: `req_count` reaches 255 and holds there.
6. **Reset mid-operation.** Assert `rst` asynchronously while `s`=1 with `req_count`=3. Required: `s`=0, `busy`=0 and `req_count`=0 immediately. After release, with the sensor still high, `s` rises only after a full 5-edge debounce.

Source files
------------

// File: rtl/side_sensor_req.sv
// Side-street vehicle sensor request generator: synchronizes and debounces the
// loop detector, then holds a latched request until the controller acknowledges it.
module side_sensor_req #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic       ack,
    output logic       s,
    output logic       busy,
    output logic [7:0] req_count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_REQ      = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        sat_inc = (value == 8'hFF) ? 8'hFF : (value + 8'd1);
    endfunction

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] req_count_q, req_count_d;
    logic       sync1_q;
    logic       sens_q, sens_d;
    logic       s_q, s_d;

    // sens_s is held low during hold-off so a sustained vehicle must re-debounce
    // from a freshly observed sample once the block is back in IDLE.
    assign sens_d = (state_q == ST_HOLDOFF) ? 1'b0 : sync1_q;

    // Next-state, counter and acknowledged-request count decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_count_d = req_count_q;
        case (state_q)
            ST_IDLE: begin
                if (sens_q) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (!sens_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_REQ;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d     = ST_HOLDOFF;
                    cnt_d       = 8'd0;
                    req_count_d = sat_inc(req_count_q);
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        s_d = (state_d == ST_REQ);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_count_q <= 8'd0;
            sync1_q     <= 1'b0;
            sens_q      <= 1'b0;
            s_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_count_q <= req_count_d;
            sync1_q     <= sensor_raw;
            sens_q      <= sens_d;
            s_q         <= s_d;
        end
    end

    assign s         = s_q;
    assign busy      = (state_q != ST_IDLE);
    assign req_count = req_count_q;

endmodule

// File: tb/tb_side_sensor_req.sv
// Directed testbench for side_sensor_req with default parameters (debounce 4, hold-off 8).
module tb_side_sensor_req;

    logic       clk;
    logic       rst;
    logic       sensor_raw;
    logic       ack;
    logic       s;
    logic       busy;
    logic [7:0] req_count;

    int vectors;
    int miscompares;

    side_sensor_req dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .ack        (ack),
        .s          (s),
        .busy       (busy),
        .req_count  (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sensor_raw  = 1'b0;
        ack         = 1'b0;

        // Reset state
        step();
        step();
        check("rst_s", s, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", req_count, 8'd0);
        rst = 1'b0;
        step();
        check("idle_busy", busy, 1'b0);

        // Basic request: edge e=0 is the first capture edge of sensor_raw
        sensor_raw = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            check("t1_s", s, (e == 5));
            check("t1_busy", busy, (e >= 2));
        end
        check("t1_count", req_count, 8'd0);

        // Acknowledge and hold-off with sensor held high: next rise 13 edges later
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t3_s_ack", s, 1'b0);
        check("t3_count", req_count, 8'd1);
        check("t3_busy_ack", busy, 1'b1);
        for (int j = 1; j <= 13; j++) begin
            step();
            check("t3_s", s, (j == 13));
            check("t3_busy", busy, (j <= 7) || (j >= 10));
        end

        // Latched request: sensor drops, s holds until ack
        step();
        step();
        sensor_raw = 1'b0;
        for (int j = 0; j < 50; j++) begin
            step();
            check("t4_s_latched", s, 1'b1);
        end
        check("t4_count_pre", req_count, 8'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_s_ack", s, 1'b0);
        check("t4_count", req_count, 8'd2);

        // ack during hold-off changes nothing; hold-off still ends 8 edges after ack
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_hold_count", req_count, 8'd2);
        check("t4_hold_busy", busy, 1'b1);
        for (int j = 2; j <= 7; j++) begin
            step();
            check("t4_hold_busy", busy, 1'b1);
        end
        step();
        check("t4_hold_end", busy, 1'b0);

        // ack in IDLE changes nothing
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_idle_busy", busy, 1'b0);
        check("t4_idle_s", s, 1'b0);
        check("t4_idle_count", req_count, 8'd2);
        step();
        check("t4_idle_busy2", busy, 1'b0);

        // Glitch rejection: 3-high / 2-low pulses
        for (int r = 0; r < 10; r++) begin
            for (int idx = 0; idx < 5; idx++) begin
                sensor_raw = (idx < 3);
                step();
                check("t2_s", s, 1'b0);
                check("t2_busy", busy, (idx >= 2));
            end
        end
        sensor_raw = 1'b0;
        step();
        check("t2_busy_end", busy, 1'b0);
        step();
        check("t2_busy_end2", busy, 1'b0);
        check("t2_count", req_count, 8'd2);

        // Boundary: a 4-cycle pulse is just long enough
        for (int e = 0; e <= 5; e++) begin
            sensor_raw = (e < 4);
            step();
            check("min_pulse_s", s, (e == 5));
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("min_pulse_count", req_count, 8'd3);

        // New request with sensor raised right after the acknowledge edge
        sensor_raw = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            step();
            check("t6_pre_s", s, (j == 13));
        end
        check("t6_pre_count", req_count, 8'd3);

        // Asynchronous reset mid-REQ
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_s", s, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_count", req_count, 8'd0);
        step();
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            step();
            check("t6_rel_s", s, (e == 5));
        end

        // Counter saturation over 260 request/acknowledge cycles
        for (int i = 0; i < 260; i++) begin
            ack = 1'b1;
            step();
            ack = 1'b0;
            check("t5_s_ack", s, 1'b0);
            check("t5_count", req_count, (i + 1 > 255) ? 255 : i + 1);
            for (int j = 1; j <= 13; j++) begin
                step();
            end
            check("t5_s_rerequest", s, 1'b1);
        end
        check("t5_count_final", req_count, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
